// File: rtl/addsub_checker.sv
// addsub_checker: two-stage response monitor for a W-bit add/subtract unit.
// Captures each valid tuple, compares it against a golden model and tracks counts and the first failure.
module addsub_checker #(
  parameter int W     = 4,
  parameter int NVEC  = 10,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vld,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             m,
  input  logic [W-1:0]     s,
  input  logic             c,
  input  logic             v,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] vec_cnt,
  output logic             fail_valid,
  output logic [CNT_W-1:0] fail_idx
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic             p_vld_q, m_q, c_q, v_q, mm_q, fv_q;
  logic [W-1:0]     a_q, b_q, s_q, bx;
  logic [W:0]       gold;
  logic [CNT_W-1:0] idx_q, vec_q, err_q, fi_q;
  logic             gv, fail, accept, go;
  always_comb begin
    bx      = m_q ? ~b_q : b_q;
    gold    = {1'b0, a_q} + {1'b0, bx} + {{W{1'b0}}, m_q};
    gv      = (a_q[W-1] == bx[W-1]) && (gold[W-1] != a_q[W-1]);
    fail    = p_vld_q && (({c_q, s_q} != gold) || (v_q != gv));
    accept  = (state_q == RUN) && vld && (vec_q != CNT_W'(NVEC));
    go      = start && (state_q == IDLE || state_q == DONE);
    state_d = go ? RUN
            : (accept && vec_q == CNT_W'(NVEC - 1)) ? DRAIN
            : (state_q == DRAIN) ? DONE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_vld_q <= 1'b0;
      {a_q, b_q, s_q, m_q, c_q, v_q} <= '0;
      idx_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      fi_q    <= '0;
      fv_q    <= 1'b0;
      mm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p_vld_q <= accept;
      mm_q    <= fail;
      if (accept) begin
        {a_q, b_q, s_q, m_q, c_q, v_q} <= {a, b, s, m, c, v};
        idx_q <= vec_q;
      end
      if (go) begin
        vec_q <= '0;
        err_q <= '0;
        fi_q  <= '0;
        fv_q  <= 1'b0;
      end else begin
        if (accept) vec_q <= vec_q + 1'b1;
        if (fail && err_q != '1) err_q <= err_q + 1'b1;
        if (fail && !fv_q) begin
          fv_q <= 1'b1;
          fi_q <= idx_q;
        end
      end
    end
  end
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = state_q == DONE;
  assign pass       = done && (err_q == '0);
  assign mismatch   = mm_q;
  assign err_cnt    = err_q;
  assign vec_cnt    = vec_q;
  assign fail_valid = fv_q;
  assign fail_idx   = fi_q;
endmodule

// File: tb/tb_addsub_checker.sv
// tb_addsub_checker: directed-vector bench for addsub_checker, plus a narrow-counter instance for saturation.
module tb_addsub_checker;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, vld = 1'b0, m = 1'b0, c = 1'b0, v = 1'b0;
  logic [3:0] a = '0, b = '0, s = '0;
  logic busy, done, pass, mismatch, fail_valid;
  logic [7:0] err_cnt, vec_cnt, fail_idx;
  logic busy2, done2, pass2, mismatch2, fail_valid2;
  logic [1:0] err_cnt2, vec_cnt2, fail_idx2;
  logic [9:0] mm_seen;
  int errs = 0, checks = 0;

  int va[10] = '{-1, 2, 2, -5, -3, 3, 7, -8, 0, -8};
  int vb[10] = '{ 2, 3, 7, -4,  5, 3, 1,  1, 0, -8};
  int vm[10] = '{ 0, 1, 0,  0,  1, 1, 0,  1, 1,  0};
  int es[10] = '{ 1,-1,-7,  7, -8, 0,-8,  7, 0,  0};
  int ec[10] = '{ 1, 0, 0,  1,  1, 1, 0,  1, 1,  1};
  int ev[10] = '{ 0, 0, 1,  1,  0, 0, 1,  1, 0,  1};

  always #5 clk = ~clk;

  addsub_checker #(.W(4), .NVEC(10), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .vld(vld), .a(a), .b(b), .m(m), .s(s), .c(c), .v(v),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch), .err_cnt(err_cnt),
    .vec_cnt(vec_cnt), .fail_valid(fail_valid), .fail_idx(fail_idx));

  addsub_checker #(.W(4), .NVEC(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .vld(vld), .a(a), .b(b), .m(m), .s(s), .c(c), .v(v),
    .busy(busy2), .done(done2), .pass(pass2), .mismatch(mismatch2), .err_cnt(err_cnt2),
    .vec_cnt(vec_cnt2), .fail_valid(fail_valid2), .fail_idx(fail_idx2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n table vectors back-to-back; emask flips v on chosen vectors, mid raises start alongside
  // that vector, sv raises vld together with the opening start. mm_seen[i] is mismatch one cycle after vector i.
  task automatic run(input int n, input logic [9:0] emask, input int mid, input bit sv);
    start = 1'b1; vld = sv; tick();
    start = 1'b0; mm_seen = '0;
    for (int i = 0; i < n; i++) begin
      vld = 1'b1; a = 4'(va[i]); b = 4'(vb[i]); m = 1'(vm[i]);
      s = 4'(es[i]); c = 1'(ec[i]); v = 1'(ev[i]) ^ emask[i]; start = (i == mid);
      tick();
      if (i > 0) mm_seen[i-1] = mismatch;
    end
    vld = 1'b0; start = 1'b0; a = 'x; b = 'x; s = 'x;
    tick();
    mm_seen[n-1] = mismatch;
  endtask

  task automatic do_reset();
    rst = 1'b1; vld = 1'b0; start = 1'b0; tick(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({busy, done, pass, mismatch, fail_valid} !== 5'b0) begin errs++; $display("FAIL reset_flags: got %b want 00000", {busy, done, pass, mismatch, fail_valid}); end
    checks++; if ({err_cnt, vec_cnt, fail_idx} !== 24'h0) begin errs++; $display("FAIL reset_cnts: got %h want 000000", {err_cnt, vec_cnt, fail_idx}); end
  endtask

  task automatic test_clean();
    run(10, 10'b0, -1, 1'b0);
    checks++; if ({done, busy, pass} !== 3'b101) begin errs++; $display("FAIL clean_done: got %b want 101", {done, busy, pass}); end
    checks++; if (err_cnt !== 8'd0) begin errs++; $display("FAIL clean_err: got %0d want 0", err_cnt); end
    checks++; if (vec_cnt !== 8'd10) begin errs++; $display("FAIL clean_vec: got %0d want 10", vec_cnt); end
    checks++; if (mm_seen !== 10'b0 || fail_valid !== 1'b0) begin errs++; $display("FAIL clean_mm: got %b/%b want 0/0", mm_seen, fail_valid); end
  endtask

  task automatic test_single();
    run(10, 10'b00_0000_1000, -1, 1'b0);
    checks++; if (mm_seen !== 10'b00_0000_1000) begin errs++; $display("FAIL single_latency: got %b want 0000001000", mm_seen); end
    checks++; if (err_cnt !== 8'd1) begin errs++; $display("FAIL single_err: got %0d want 1", err_cnt); end
    checks++; if (fail_valid !== 1'b1 || fail_idx !== 8'd3) begin errs++; $display("FAIL single_idx: got %b/%0d want 1/3", fail_valid, fail_idx); end
    checks++; if ({done, pass} !== 2'b10) begin errs++; $display("FAIL single_pass: got %b want 10", {done, pass}); end
  endtask

  task automatic test_double();
    for (int r = 0; r < 2; r++) begin
      run(10, 10'b00_1000_0100, -1, 1'b0);
      checks++; if (err_cnt !== 8'd2) begin errs++; $display("FAIL double_err[%0d]: got %0d want 2", r, err_cnt); end
      checks++; if (fail_idx !== 8'd2 || fail_valid !== 1'b1) begin errs++; $display("FAIL double_idx[%0d]: got %b/%0d want 1/2", r, fail_valid, fail_idx); end
      checks++; if (mm_seen !== 10'b00_1000_0100) begin errs++; $display("FAIL double_mm[%0d]: got %b want 0010000100", r, mm_seen); end
    end
  endtask

  task automatic test_ignored();
    do_reset();
    vld = 1'b1; a = 4'd1; b = 4'd1; s = 4'd7; tick(); vld = 1'b0; tick();
    checks++; if ({busy, done, mismatch, vec_cnt, err_cnt} !== 19'h0) begin errs++; $display("FAIL idle_vld: got %h want 0", {busy, done, mismatch, vec_cnt, err_cnt}); end
    run(10, 10'b00_0010_0000, 6, 1'b1);
    checks++; if (vec_cnt !== 8'd10 || done !== 1'b1) begin errs++; $display("FAIL midstart_vec: got %0d/%b want 10/1", vec_cnt, done); end
    checks++; if (err_cnt !== 8'd1 || fail_idx !== 8'd5) begin errs++; $display("FAIL midstart_err: got %0d/%0d want 1/5", err_cnt, fail_idx); end
    vld = 1'b1; a = 4'd1; s = 4'd9; tick(); vld = 1'b0; tick();
    checks++; if (vec_cnt !== 8'd10 || done !== 1'b1 || err_cnt !== 8'd1) begin errs++; $display("FAIL done_vld: got %0d/%b/%0d want 10/1/1", vec_cnt, done, err_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vld = 1'b1; a = 4'(va[i]); b = 4'(vb[i]); m = 1'(vm[i]);
      s = 4'(es[i]); c = 1'(ec[i]); v = 1'(ev[i]) ^ (i == 2);
      tick();
    end
    vld = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (mismatch !== 1'b0) begin errs++; $display("FAIL rstmid_mm: got %b want 0", mismatch); end
    checks++; if ({busy, done, pass, fail_valid, vec_cnt, err_cnt, fail_idx} !== 28'h0) begin errs++; $display("FAIL rstmid_outs: got %h want 0", {busy, done, pass, fail_valid, vec_cnt, err_cnt, fail_idx}); end
    tick();
    checks++; if (mismatch !== 1'b0 || err_cnt !== 8'd0) begin errs++; $display("FAIL rstmid_after: got %b/%0d want 0/0", mismatch, err_cnt); end
  endtask

  task automatic test_sat();
    do_reset();
    run(3, 10'b00_0000_0111, -1, 1'b0);
    checks++; if (err_cnt2 !== 2'b11) begin errs++; $display("FAIL sat_err: got %0d want 3", err_cnt2); end
    checks++; if ({done2, pass2, fail_valid2, fail_idx2, vec_cnt2} !== 7'b1010011) begin errs++; $display("FAIL sat_state: got %b want 1010011", {done2, pass2, fail_valid2, fail_idx2, vec_cnt2}); end
    checks++; if (mm_seen[2:0] !== 3'b111) begin errs++; $display("FAIL sat_mm: got %b want 111", mm_seen[2:0]); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_ignored();
    test_reset_mid();
    test_sat();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
